// File: rtl/aa_frame_ctrl.sv
// Anti-aliasing frame sequencer: raster-scans a WIDTH x HEIGHT frame, gathers each pixel
// with its four orthogonal neighbours, and writes the edge-filtered or original pixel.
module aa_frame_ctrl #(
    parameter int WIDTH  = 64,
    parameter int HEIGHT = 48,
    parameter int PIX_W  = 8,
    parameter int ADDR_W = 12
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_start,
    input  logic [PIX_W-1:0]  i_th,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_rd_en,
    output logic [ADDR_W-1:0] o_rd_addr,
    input  logic [PIX_W-1:0]  i_rd_data,
    output logic              o_wr_en,
    output logic [ADDR_W-1:0] o_wr_addr,
    output logic [PIX_W-1:0]  o_wr_data,
    output logic [ADDR_W-1:0] o_edge_cnt
);

    // state   | meaning
    // IDLE    | waiting for start
    // READ    | issuing reads (1 for border, 5 for interior: C,N,S,W,E)
    // WAIT    | last read datum returns
    // WRITE   | write result, advance raster position
    // DONE    | one-cycle completion pulse
    typedef enum logic [2:0] {S_IDLE, S_READ, S_WAIT, S_WRITE, S_DONE} state_t;

    localparam logic [ADDR_W-1:0] COL_LAST = ADDR_W'(WIDTH - 1);
    localparam logic [ADDR_W-1:0] ROW_LAST = ADDR_W'(HEIGHT - 1);
    localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(WIDTH);
    localparam logic [ADDR_W-1:0] ONE      = ADDR_W'(1);

    state_t              r_state;
    state_t              w_next;
    logic [ADDR_W-1:0]   r_row;
    logic [ADDR_W-1:0]   r_col;
    logic [ADDR_W-1:0]   r_addr;
    logic [2:0]          r_idx;
    logic                r_pend;
    logic [2:0]          r_pend_idx;
    logic [PIX_W-1:0]    r_th;
    logic [PIX_W-1:0]    r_c, r_n, r_s, r_w, r_e;
    logic [ADDR_W-1:0]   r_edge_cnt;

    logic                w_border;
    logic                w_last_pix;
    logic [PIX_W+1:0]    w_sum;
    logic [PIX_W-1:0]    w_avg;
    logic                w_edge;
    logic [PIX_W-1:0]    w_pix_out;
    logic [ADDR_W-1:0]   w_rd_addr;

    assign w_border   = (r_row == '0) || (r_row == ROW_LAST) ||
                        (r_col == '0) || (r_col == COL_LAST);
    assign w_last_pix = (r_row == ROW_LAST) && (r_col == COL_LAST);
    assign w_sum      = {2'b00, r_n} + {2'b00, r_s} + {2'b00, r_w} + {2'b00, r_e};
    assign w_avg      = PIX_W'(w_sum >> 2);
    assign w_edge     = !w_border && (r_c > r_th) &&
                        ((r_n < r_th) || (r_s < r_th) || (r_w < r_th) || (r_e < r_th));
    assign w_pix_out  = w_edge ? w_avg : r_c;

    always_comb begin
        case (r_idx)
            3'd1:    w_rd_addr = r_addr - ROW_STEP;
            3'd2:    w_rd_addr = r_addr + ROW_STEP;
            3'd3:    w_rd_addr = r_addr - ONE;
            3'd4:    w_rd_addr = r_addr + ONE;
            default: w_rd_addr = r_addr;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) r_state <= S_IDLE;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (i_start) w_next = S_READ;
            S_READ:  if (w_border || (r_idx == 3'd4)) w_next = S_WAIT;
            S_WAIT:  w_next = S_WRITE;
            S_WRITE: w_next = w_last_pix ? S_DONE : S_READ;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        o_busy     = (r_state != S_IDLE);
        o_done     = (r_state == S_DONE);
        o_rd_en    = 1'b0;
        o_rd_addr  = '0;
        o_wr_en    = 1'b0;
        o_wr_addr  = '0;
        o_wr_data  = '0;
        o_edge_cnt = r_edge_cnt;
        if (r_state == S_READ) begin
            o_rd_en   = 1'b1;
            o_rd_addr = w_rd_addr;
        end
        if (r_state == S_WRITE) begin
            o_wr_en   = 1'b1;
            o_wr_addr = r_addr;
            o_wr_data = w_pix_out;
        end
    end

    // Read data lands one cycle after its strobe; r_pend_idx steers it to the right slot.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_row      <= '0;
            r_col      <= '0;
            r_addr     <= '0;
            r_idx      <= '0;
            r_pend     <= 1'b0;
            r_pend_idx <= '0;
            r_th       <= '0;
            r_c        <= '0;
            r_n        <= '0;
            r_s        <= '0;
            r_w        <= '0;
            r_e        <= '0;
            r_edge_cnt <= '0;
        end else begin
            r_pend     <= o_rd_en;
            r_pend_idx <= r_idx;
            if (r_pend) begin
                case (r_pend_idx)
                    3'd0:    r_c <= i_rd_data;
                    3'd1:    r_n <= i_rd_data;
                    3'd2:    r_s <= i_rd_data;
                    3'd3:    r_w <= i_rd_data;
                    default: r_e <= i_rd_data;
                endcase
            end
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_th       <= i_th;
                        r_row      <= '0;
                        r_col      <= '0;
                        r_addr     <= '0;
                        r_idx      <= '0;
                        r_edge_cnt <= '0;
                    end
                end
                S_READ: begin
                    r_idx <= (w_next == S_READ) ? 3'(r_idx + 3'd1) : 3'd0;
                end
                S_WRITE: begin
                    if (w_edge) r_edge_cnt <= r_edge_cnt + ONE;
                    r_addr <= r_addr + ONE;
                    if (r_col == COL_LAST) begin
                        r_col <= '0;
                        r_row <= r_row + ONE;
                    end else begin
                        r_col <= r_col + ONE;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_aa_frame_ctrl.sv
// Scoreboard bench for aa_frame_ctrl on a 4x4 frame: expected writes are queued per pass
// and a negedge monitor pops and compares every write strobe.
module tb_aa_frame_ctrl;

    localparam int W      = 4;
    localparam int H      = 4;
    localparam int AW     = 8;
    localparam int P_DONE = 65;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [7:0]    th;
    logic          busy, done, rd_en, wr_en;
    logic [AW-1:0] rd_addr, wr_addr, edge_cnt;
    logic [7:0]    rd_data = 8'd0;
    logic [7:0]    wr_data;

    logic [7:0]    mem [256];
    logic [7:0]    exp_frame [16];
    logic [15:0]   sb_q [$];
    logic [15:0]   sb_e;
    int            rd_cnt = 0;
    int            n_tests = 0;
    int            n_fail = 0;

    always #5 clk = ~clk;

    aa_frame_ctrl #(.WIDTH(W), .HEIGHT(H), .PIX_W(8), .ADDR_W(AW)) dut (
        .i_clk(clk), .i_reset(reset), .i_start(start), .i_th(th),
        .o_busy(busy), .o_done(done), .o_rd_en(rd_en), .o_rd_addr(rd_addr),
        .i_rd_data(rd_data), .o_wr_en(wr_en), .o_wr_addr(wr_addr),
        .o_wr_data(wr_data), .o_edge_cnt(edge_cnt)
    );

    always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

    task automatic check(input string name, input int act, input int expv);
        n_tests++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    function automatic int is_border(input int a);
        int r, c;
        r = a / W;
        c = a % W;
        return ((r == 0) || (r == H - 1) || (c == 0) || (c == W - 1)) ? 1 : 0;
    endfunction

    always @(negedge clk) begin
        if (reset) begin
            rd_cnt = 0;
        end else begin
            if (rd_en && wr_en) check("rd_wr_overlap", 1, 0);
            if (rd_en) rd_cnt++;
            if (wr_en) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_write", 1, 0);
                end else begin
                    sb_e = sb_q.pop_front();
                    check("wr_addr", int'(wr_addr), int'(sb_e[15:8]));
                    check($sformatf("wr_data@%0d", sb_e[15:8]), int'(wr_data), int'(sb_e[7:0]));
                    check($sformatf("reads@%0d", sb_e[15:8]), rd_cnt,
                          (is_border(int'(wr_addr)) != 0) ? 1 : 5);
                end
                rd_cnt = 0;
            end
        end
    end

    task automatic clear_frame();
        for (int i = 0; i < 256; i++) mem[i] = 8'd0;
    endtask

    task automatic load_expect();
        for (int i = 0; i < 16; i++) exp_frame[i] = mem[i];
    endtask

    // Called at a negedge while the DUT is idle; start is sampled at the next posedge.
    task automatic run_pass(input string tag, input logic [7:0] th_v, input int exp_cnt,
                            input int inj_cyc, input int rst_cyc);
        int cyc;
        int activity;
        bit seen;
        for (int i = 0; i < 16; i++) sb_q.push_back({8'(i), exp_frame[i]});
        start = 1'b1;
        th    = th_v;
        @(negedge clk);
        start = 1'b0;
        cyc   = 1;
        check({tag, "_busy_c1"}, int'(busy), 1);
        check({tag, "_rd_en_c1"}, int'(rd_en), 1);
        check({tag, "_rd_addr_c1"}, int'(rd_addr), 0);
        check({tag, "_edge_cnt_clr"}, int'(edge_cnt), 0);
        seen = 1'b0;
        while (!seen && cyc < 300) begin
            if (cyc == inj_cyc) begin
                start = 1'b1;
                th    = 8'd250;
            end else if (cyc == inj_cyc + 1) begin
                start = 1'b0;
                th    = th_v;
            end
            if (cyc == rst_cyc) begin
                check({tag, "_edge_cnt_pre_rst"}, int'(edge_cnt), 1);
                reset = 1'b1;
                @(negedge clk);
                check({tag, "_rst_busy"}, int'(busy), 0);
                check({tag, "_rst_rd_en"}, int'(rd_en), 0);
                check({tag, "_rst_wr_en"}, int'(wr_en), 0);
                check({tag, "_rst_done"}, int'(done), 0);
                check({tag, "_rst_edge_cnt"}, int'(edge_cnt), 0);
                reset = 1'b0;
                sb_q.delete();
                activity = 0;
                repeat (60) begin
                    @(negedge clk);
                    if (busy || done || rd_en || wr_en) activity++;
                end
                check({tag, "_post_rst_activity"}, activity, 0);
                rd_cnt = 0;
                return;
            end
            if (done) seen = 1'b1;
            else begin
                @(negedge clk);
                cyc++;
            end
        end
        check({tag, "_done_cycle"}, cyc, P_DONE);
        check({tag, "_edge_cnt"}, int'(edge_cnt), exp_cnt);
        @(negedge clk);
        check({tag, "_busy_low"}, int'(busy), 0);
        check({tag, "_edge_cnt_hold"}, int'(edge_cnt), exp_cnt);
        check({tag, "_sb_empty"}, sb_q.size(), 0);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        th    = 8'd0;
        clear_frame();
        repeat (3) @(negedge clk);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_rd_en", int'(rd_en), 0);
        check("rst_rd_addr", int'(rd_addr), 0);
        check("rst_wr_en", int'(wr_en), 0);
        check("rst_wr_addr", int'(wr_addr), 0);
        check("rst_wr_data", int'(wr_data), 0);
        check("rst_edge_cnt", int'(edge_cnt), 0);
        reset = 1'b0;
        @(negedge clk);

        // single bright interior pixel on black: filtered to 0
        clear_frame();
        mem[5] = 8'd200;
        load_expect();
        exp_frame[5] = 8'd0;
        run_pass("t1", 8'd100, 1, -1, -1);

        // back-to-back start; (10+20+30+41)>>2 = 25
        clear_frame();
        mem[5] = 8'd150; mem[1] = 8'd10; mem[9] = 8'd20; mem[4] = 8'd30; mem[6] = 8'd41;
        load_expect();
        exp_frame[5] = 8'd25;
        run_pass("t2", 8'd100, 1, -1, -1);

        // centre equal to threshold: not filtered
        mem[5] = 8'd100;
        load_expect();
        run_pass("t3", 8'd100, 0, -1, -1);

        // neighbours equal to threshold: not filtered
        clear_frame();
        mem[5] = 8'd200; mem[1] = 8'd100; mem[9] = 8'd100; mem[4] = 8'd100; mem[6] = 8'd100;
        load_expect();
        run_pass("t4", 8'd100, 0, -1, -1);

        // bright border pixel: written unchanged with a single read
        clear_frame();
        mem[2] = 8'd255;
        load_expect();
        run_pass("t5", 8'd10, 0, -1, -1);

        // start pulsed mid-pass with a different threshold is ignored
        clear_frame();
        mem[5] = 8'd200;
        load_expect();
        exp_frame[5] = 8'd0;
        run_pass("t6", 8'd100, 1, 10, -1);

        // reset during interior pixel (1,2) reads
        run_pass("t7", 8'd100, 1, -1, 25);

        // recovery pass after reset
        load_expect();
        exp_frame[5] = 8'd0;
        run_pass("t8", 8'd100, 1, -1, -1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/aa_frame_ctrl.md
# aa_frame_ctrl

Sequencing controller for the anti-aliasing pass: on `start` it raster-scans a WIDTH×HEIGHT frame held in single-port read memory, fetches each pixel and its four orthogonal neighbours, applies the threshold edge test, and writes the filtered or unchanged pixel to an output frame memory. It sits between the frame buffer (read side) and the display/output buffer (write side) and reports completion with a one-cycle `done` pulse.

## Interface
- `WIDTH`, 64, pixels per row (≥3)
- `HEIGHT`, 48, rows per frame (≥3)
- `PIX_W`, 8, pixel width in bits
- `ADDR_W`, 12, address width; 2^ADDR_W ≥ WIDTH*HEIGHT

- `clk` in 1: single clock; all logic on rising edge
- `reset` in 1: synchronous, active-high
- `start` in 1: begin one frame pass; honoured only in IDLE
- `th` in PIX_W: threshold, latched when `start` is accepted
- `busy` out 1: pass in progress
- `done` out 1: one-cycle pulse at end of pass
- `rd_en` out 1: read strobe to input frame memory
- `rd_addr` out ADDR_W: read address, row*WIDTH+col
- `rd_data` in PIX_W: read data, valid exactly 1 cycle after `rd_en`
- `wr_en` out 1: write strobe to output frame memory
- `wr_addr` out ADDR_W: write address
- `wr_data` out PIX_W: write data
- `edge_cnt` out ADDR_W: number of pixels filtered in the current/last pass

## Operation
- Reset value of every output: 0. `edge_cnt` holds its value after `done` until the next accepted `start` clears it.
- States: IDLE, READ, WAIT, WRITE, DONE.
- IDLE: on `start`=1, latch `th`, row=col=0, clear `edge_cnt`, go READ. `start` in any other state is ignored.
- Border pixel (row 0, row HEIGHT-1, col 0 or col WIDTH-1): READ issues 1 read (centre), then WAIT, then WRITE with `wr_data` = centre.
- Interior pixel: READ issues 5 reads on consecutive cycles in order centre C, north (addr-WIDTH), south (addr+WIDTH), west (addr-1), east (addr+1); WAIT captures the last datum; WRITE.
- Edge test (interior only): C > th AND any of N,S,W,E < th (both strict). If true, `wr_data` = (N+S+W+E)>>2 with the sum in PIX_W+2 bits, truncated, and `edge_cnt` increments in the WRITE cycle; else `wr_data` = C.
- `wr_addr` = centre address of the current pixel.
- After WRITE: advance col; at col=WIDTH-1 wrap col to 0 and advance row. After the WRITE of (HEIGHT-1, WIDTH-1) go DONE; otherwise go READ.
- DONE: `done`=1 for this cycle, then IDLE.
- Reset asserted mid-pass: next cycle all outputs 0, state IDLE, no further `rd_en`/`wr_en`; the partial output frame is not cleaned up.

## Timing
- Cycle 0: `start` sampled in IDLE. Cycle 1: first `rd_en` (addr 0), `busy`=1.
- Border pixel: 3 cycles (READ, WAIT, WRITE). Interior pixel: 7 cycles (5 READ, WAIT, WRITE).
- `rd_en` deasserted in WAIT and WRITE; exactly one `wr_en` per pixel, in raster order.
- Pass length P = 3*(2*WIDTH+2*HEIGHT-4) + 7*(WIDTH-2)*(HEIGHT-2) cycles; `done` in cycle P+1.
- `busy` high from cycle 1 through the `done` cycle inclusive; low in the following cycle; `start` in that cycle is accepted.
- `wr_en` and `rd_en` never asserted in the same cycle.

## Test plan
- WIDTH=HEIGHT=4, all-zero frame except (1,1)=200, th=100 -> write to addr 5 = 0, all other 15 writes equal input, `edge_cnt`=1, `done` in cycle 65 after start.
- Interior C=150, N=10, S=20, W=30, E=41, th=100 -> `wr_data`=25 at that address; same with C=100 (equal to th) -> `wr_data`=100, no increment.
- Neighbours all equal to th=100, C=200 -> not filtered, `wr_data`=200.
- Border pixel (0,2)=255 with neighbours 0, th=10 -> written 255 unchanged, exactly 1 `rd_en` for that pixel.
- `start` pulsed while `busy` -> ignored, `th` unchanged, pass completes with the original P timing; `start` the cycle after `busy` falls -> new pass begins, `edge_cnt` cleared.
- `reset` asserted mid-interior-pixel -> next cycle `busy`,`rd_en`,`wr_en`,`done`,`edge_cnt` all 0, no `done` pulse follows.
